// File: rtl/lifo_stack_reg_if.sv
// Bundle of the LIFO stack data, request and status signals.
// Ovf/Unf exist only when STACK_ERR_EN is defined.
interface lifo_stack_reg_if #(
    parameter int N  = 8,
    parameter int AW = 3
);
    logic [N-1:0] In;
    logic         Push;
    logic         Pop;
    logic [N-1:0] Out;
    logic         Full;
    logic         Empty;
    logic [AW:0]  Count;
`ifdef STACK_ERR_EN
    logic         Ovf;
    logic         Unf;
`endif

    modport master (
        output In, Push, Pop,
        input  Out, Full, Empty, Count
`ifdef STACK_ERR_EN
        , input Ovf, Unf
`endif
    );

    modport slave (
        input  In, Push, Pop,
        output Out, Full, Empty, Count
`ifdef STACK_ERR_EN
        , output Ovf, Unf
`endif
    );
endinterface

// File: rtl/lifo_stack_reg.sv
// Clocked LIFO stack: register file, stack pointer, decoded flags.
// Optional sticky Ovf/Unf flags when STACK_ERR_EN is defined.
module lifo_stack_reg #(
    parameter int N     = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             Clk,
    input  logic             Rst,
    lifo_stack_reg_if.slave  bus
);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [N-1:0]  mem_q [DEPTH];
    logic [AW:0]   sp_q;
    logic [AW:0]   sp_d;
    logic [AW:0]   sp_m1;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] wr_idx;
    logic          full;
    logic          empty;
    logic          do_repl;
    logic          do_push;
    logic          do_pop;
    logic          we;

    assign full    = (sp_q == DEPTH_W);
    assign empty   = (sp_q == '0);
    assign sp_m1   = sp_q - 1'b1;
    assign top_idx = sp_m1[AW-1:0];

    // Pop&Push on an empty stack falls through to a plain push.
    assign do_repl = bus.Push & bus.Pop & ~empty;
    assign do_push = bus.Push & ~do_repl & ~full;
    assign do_pop  = bus.Pop & ~bus.Push & ~empty;
    assign we      = do_repl | do_push;
    assign wr_idx  = do_repl ? top_idx : sp_q[AW-1:0];

    // Next stack pointer; replace and blocked ops leave it alone.
    always_comb begin
        sp_d = sp_q;
        if (do_push) begin
            sp_d = sp_q + 1'b1;
        end else if (do_pop) begin
            sp_d = sp_m1;
        end
    end

    // Stack pointer with asynchronous clear.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Storage array is never cleared; writes are suppressed during reset.
    always_ff @(posedge Clk) begin
        if (!Rst && we) begin
            mem_q[wr_idx] <= bus.In;
        end
    end

    assign bus.Out   = empty ? '0 : mem_q[top_idx];
    assign bus.Full  = full;
    assign bus.Empty = empty;
    assign bus.Count = sp_q;

`ifdef STACK_ERR_EN
    logic ovf_q;
    logic unf_q;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (bus.Push && !bus.Pop && full) begin
                ovf_q <= 1'b1;
            end
            if (bus.Pop && !bus.Push && empty) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign bus.Ovf = ovf_q;
    assign bus.Unf = unf_q;
`endif
endmodule
